regfile_op_sequencer: RTL
=========================

// Module: regfile_op_sequencer
// PURPOSE
//  Initiator/master for the 16x16 add-and-write register file (2 comb read ports, sync write of rs1+rs2).
//  Buffers add commands {rs1,rs2,rd} in a FIFO and issues them one at a time as a single-cycle rf_w_en pulse.
//  Captures the register file's registered writedata and returns it with rd on a valid/ready response channel.
//  Sits between the command source (test driver / future decoder) and the register file.
// PARAMETERS
//  DEPTH   4   command FIFO entries; power of 2, >=2
//  AW      4   register address width (16 registers)
//  DW      16  register data width
// PORTS
//  clk           in   1       clock, all logic on posedge
//  rst           in   1       reset, synchronous, active-high
//  cmd_valid     in   1       command offered
//  cmd_ready     out  1       FIFO can accept; = (count < DEPTH), from registered count
//  cmd_rs1       in   AW      source address 1
//  cmd_rs2       in   AW      source address 2
//  cmd_rd        in   AW      destination address
//  rf_readaddr1  out  AW      to register file readaddr1
//  rf_readaddr2  out  AW      to register file readaddr2
//  rf_writeaddr  out  AW      to register file writeaddr
//  rf_w_en       out  1       to register file w_en; 1-cycle pulse per command
//  rf_writedata  in   DW      from register file writedata (registered sum)
//  rsp_valid     out  1       response held valid until accepted
//  rsp_ready     in   1       response sink ready
//  rsp_data      out  DW      result written to rd
//  rsp_rd        out  AW      destination of this result
//  busy          out  1       state != IDLE or count != 0
//  count         out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (clk edge with rst=1): state=IDLE, FIFO ptrs/count=0, rf_w_en=0, rf_* addrs=0, rsp_valid=0,
//   rsp_data=0, rsp_rd=0. Reset mid-operation discards FIFO contents and any pending response,
//   and drops rf_w_en in the same edge; rst dominates all other inputs.
//  Push: cmd_valid & cmd_ready at an edge writes {rs1,rs2,rd} at wr_ptr; ptr wraps mod DEPTH.
//  Full: cmd_ready=0 while count==DEPTH, even if a pop happens that cycle (no pass-through).
//  Simultaneous push+pop: count unchanged, both ptrs advance.
//  FSM (registered, one-hot or binary):
//   IDLE:    count!=0 -> ISSUE, else stay.
//   ISSUE:   rf_w_en=1, rf_readaddr1/2=head rs1/rs2, rf_writeaddr=head rd (all registered, valid whole cycle);
//            pop head at end of cycle -> CAPTURE.
//   CAPTURE: rf_w_en=0; rsp_data<=rf_writedata, rsp_rd<=issued rd, rsp_valid<=1 -> RESP.
//   RESP:    hold rsp_*; on rsp_valid&rsp_ready: rsp_valid<=0; count!=0 -> ISSUE else IDLE.
//  rf_w_en is 1 only in ISSUE; addresses hold last issued values otherwise.
//  Latency: cmd accepted at edge T into empty FIFO in IDLE -> ISSUE cycle T+1 -> rsp_valid high from T+3.
//  Throughput: one command per 3 cycles when rsp_ready held high.
//  Arithmetic: sum is rs1+rs2 mod 2^DW (computed by the register file); sequencer relays, no widening.
//  Ordering: responses in command order; a command reading an earlier command's rd sees the updated
//   value (its ISSUE is >=2 edges after the prior write).
//  rd==rs1/rs2 legal: read uses the pre-write value in ISSUE.
//  busy=0 only when IDLE and FIFO empty.
// TESTING (register file attached, its reset state mem[i]=i)
//  1 Reset, cmd{rs1=2,rs2=3,rd=5} -> rf_w_en pulses once; rsp_valid at T+3, rsp_data=5, rsp_rd=5.
//  2 Dependent chain {2,3,5},{5,5,1},{1,1,0} back-to-back -> responses 5,10,20 in order; mem[0]=20.
//  3 Overflow: preload r7=0xFFFF via repeated adds, cmd{7,1,8} -> rsp_data=0x0000 (wrap mod 2^16).
//  4 Backpressure: rsp_ready=0, push 6 cmds -> 1 issued, 4 in FIFO, cmd_ready=0, count=4;
//    rsp_ready=1 -> all 5 responses drain in order, busy falls to 0.
//  5 Reset mid-op: assert rst during ISSUE with 3 queued -> next edge rf_w_en=0, count=0, rsp_valid=0;
//    no further writes reach the register file.
//  6 Push+pop same cycle at count=2 -> count stays 2; ptr wrap after 5 sequential cmds -> correct data.

Source files
------------

// File: rtl/regfile_op_sequencer_if.sv
// Command, register-file and response signals between the add-op sequencer and its neighbours.
// master = the sequencer; slave = the command source, register file and response sink seen as one.
interface regfile_op_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [AW-1:0]           cmd_rs1;
    logic [AW-1:0]           cmd_rs2;
    logic [AW-1:0]           cmd_rd;

    logic [AW-1:0]           rf_readaddr1;
    logic [AW-1:0]           rf_readaddr2;
    logic [AW-1:0]           rf_writeaddr;
    logic                    rf_w_en;
    logic [DW-1:0]           rf_writedata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DW-1:0]           rsp_data;
    logic [AW-1:0]           rsp_rd;

    logic                    busy;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        input  cmd_valid, cmd_rs1, cmd_rs2, cmd_rd,
        output cmd_ready,
        output rf_readaddr1, rf_readaddr2, rf_writeaddr, rf_w_en,
        input  rf_writedata,
        output rsp_valid, rsp_data, rsp_rd,
        input  rsp_ready,
        output busy, count
    );

    modport slave (
        output cmd_valid, cmd_rs1, cmd_rs2, cmd_rd,
        input  cmd_ready,
        input  rf_readaddr1, rf_readaddr2, rf_writeaddr, rf_w_en,
        output rf_writedata,
        input  rsp_valid, rsp_data, rsp_rd,
        output rsp_ready,
        input  busy, count
    );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Queues {rs1,rs2,rd} add commands and issues them one at a time to a 2R1W register file,
// returning the registered sum with its destination on a valid/ready response channel.
module regfile_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_op_sequencer_if.master    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 3 * AW;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state_reg;

    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;

    logic            rf_w_en_reg;
    logic [AW-1:0]   rf_readaddr1_reg;
    logic [AW-1:0]   rf_readaddr2_reg;
    logic [AW-1:0]   rf_writeaddr_reg;
    logic            rsp_valid_reg;
    logic [DW-1:0]   rsp_data_reg;
    logic [AW-1:0]   rsp_rd_reg;

    logic            cmd_ready;
    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic            start_issue;
    logic [EW-1:0]   head;
    logic [AW-1:0]   head_rs1;
    logic [AW-1:0]   head_rs2;
    logic [AW-1:0]   head_rd;

    // Ready comes only from the registered count, so a full FIFO never passes a command through.
    assign cmd_ready     = (count_reg < FULL_COUNT);
    assign push          = bus.cmd_valid && cmd_ready;
    assign pop           = (state_reg == ISSUE);
    assign fifo_nonempty = (count_reg != '0);

    assign head     = fifo_mem[rd_ptr_reg];
    assign head_rs1 = head[EW-1 -: AW];
    assign head_rs2 = head[EW-AW-1 -: AW];
    assign head_rd  = head[AW-1:0];

    // A new issue starts from IDLE, or straight out of RESP on the cycle the response is taken.
    assign start_issue = fifo_nonempty &&
                         ((state_reg == IDLE) || (state_reg == RESP && bus.rsp_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {bus.cmd_rs1, bus.cmd_rs2, bus.cmd_rd};
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rf_w_en_reg      <= 1'b0;
            rf_readaddr1_reg <= '0;
            rf_readaddr2_reg <= '0;
            rf_writeaddr_reg <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_data_reg     <= '0;
            rsp_rd_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_issue) begin
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    rf_w_en_reg <= 1'b0;
                    state_reg   <= CAPTURE;
                end
                CAPTURE: begin
                    // rf_writeaddr still holds the rd of the command just written.
                    rsp_data_reg  <= bus.rf_writedata;
                    rsp_rd_reg    <= rf_writeaddr_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= start_issue ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (start_issue) begin
                rf_w_en_reg      <= 1'b1;
                rf_readaddr1_reg <= head_rs1;
                rf_readaddr2_reg <= head_rs2;
                rf_writeaddr_reg <= head_rd;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.rf_w_en      = rf_w_en_reg;
    assign bus.rf_readaddr1 = rf_readaddr1_reg;
    assign bus.rf_readaddr2 = rf_readaddr2_reg;
    assign bus.rf_writeaddr = rf_writeaddr_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_data     = rsp_data_reg;
    assign bus.rsp_rd       = rsp_rd_reg;
    assign bus.count        = count_reg;
    assign bus.busy         = (state_reg != IDLE) || fifo_nonempty;
endmodule
